// File: rtl/controller_fsm.sv
// Multi-cycle control unit for dataPath: sequences FETCH/EXEC/MEM per 19-bit instruction and
// decodes every datapath control strobe from the current state and the latched IR.
module controller_fsm #(
  parameter int INSTR_W     = 19,
  parameter int MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               COutput,
  input  logic               ZOutput,
  output logic               pcEn,
  output logic [1:0]         pc3inputMuxSelectAddress,
  output logic               push,
  output logic               pop,
  output logic               RET,
  output logic               CEn,
  output logic               ZEn,
  output logic               regWrite,
  output logic               regFileReadRegister2Select,
  output logic               ALUBInputSelect,
  output logic [2:0]         ALUOperation,
  output logic [1:0]         regFileWriteDataSelect,
  output logic [1:0]         SHROOperation,
  output logic               DMMemWrite,
  output logic               DMMemRead,
  output logic [1:0]         state_dbg
);

  localparam int         TOP      = INSTR_W - 1;
  localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [2:0]         cnt_q, cnt_d;

  logic [2:0] op3;
  logic [1:0] fn;
  logic       br_taken;
  logic       unused_ir;

  // Only the opcode/function bits steer control; operand fields belong to dataPath.
  assign op3       = ir_q[TOP -: 3];
  assign fn        = ir_q[TOP-3 -: 2];
  assign unused_ir = ^ir_q[TOP-5:0];
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    br_taken = 1'b0;
    case (fn)
      2'b00: br_taken = ZOutput;
      2'b01: br_taken = !ZOutput;
      2'b10: br_taken = COutput;
      2'b11: br_taken = !COutput;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d                    = state_q;
    ir_d                       = ir_q;
    cnt_d                      = cnt_q;
    pcEn                       = 1'b0;
    pc3inputMuxSelectAddress   = 2'b00;
    push                       = 1'b0;
    pop                        = 1'b0;
    RET                        = 1'b0;
    CEn                        = 1'b0;
    ZEn                        = 1'b0;
    regWrite                   = 1'b0;
    regFileReadRegister2Select = 1'b0;
    ALUBInputSelect            = 1'b0;
    ALUOperation               = 3'b000;
    regFileWriteDataSelect     = 2'b00;
    SHROOperation              = 2'b00;
    DMMemWrite                 = 1'b0;
    DMMemRead                  = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        regFileReadRegister2Select = 1'b1;
        ALUOperation               = ir_q[TOP-2 -: 3];
        SHROOperation              = fn;
        state_d                    = S_FETCH;
        if (!op3[2]) begin
          regWrite        = 1'b1;
          CEn             = 1'b1;
          ZEn             = 1'b1;
          ALUBInputSelect = op3[1];
          pcEn            = 1'b1;
        end else begin
          case (op3[1:0])
            2'b00: begin
              case (fn)
                2'b00: begin
                  DMMemRead       = 1'b1;
                  ALUBInputSelect = 1'b1;
                  cnt_d           = 3'd0;
                  state_d         = S_MEM;
                end
                2'b01: begin
                  DMMemWrite                 = 1'b1;
                  regFileReadRegister2Select = 1'b0;
                  ALUBInputSelect            = 1'b1;
                  pcEn                       = 1'b1;
                end
                default: pcEn = 1'b1;
              endcase
            end
            2'b01: begin
              pcEn = 1'b1;
              if (br_taken) pc3inputMuxSelectAddress = 2'b01;
            end
            2'b10: begin
              regWrite               = 1'b1;
              CEn                    = 1'b1;
              ZEn                    = 1'b1;
              regFileWriteDataSelect = 2'b10;
              pcEn                   = 1'b1;
            end
            default: begin
              pcEn = 1'b1;
              case (fn)
                2'b00: pc3inputMuxSelectAddress = 2'b10;
                2'b01: begin
                  pc3inputMuxSelectAddress = 2'b10;
                  push                     = 1'b1;
                end
                2'b10: begin
                  pc3inputMuxSelectAddress = 2'b11;
                  pop                      = 1'b1;
                  RET                      = 1'b1;
                end
                default: pc3inputMuxSelectAddress = 2'b00;
              endcase
            end
          endcase
        end
      end

      S_MEM: begin
        // ALU B stays on the immediate so the load address is stable for the whole read.
        regFileReadRegister2Select = 1'b1;
        ALUOperation               = ir_q[TOP-2 -: 3];
        SHROOperation              = fn;
        ALUBInputSelect            = 1'b1;
        DMMemRead                  = 1'b1;
        if (cnt_q == LAST_CNT) begin
          regWrite               = 1'b1;
          regFileWriteDataSelect = 2'b01;
          pcEn                   = 1'b1;
          cnt_d                  = 3'd0;
          state_d                = S_FETCH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  a_push_pop: assert property (@(posedge clk) disable iff (!rst) !(push && pop));
  a_rw_dmw:   assert property (@(posedge clk) disable iff (!rst) !(regWrite && DMMemWrite));

endmodule

// File: tb/tb_controller_fsm.sv
// Directed bench for controller_fsm: an instruction-level model predicts every cycle's outputs,
// one compare process checks them at the falling edge, plus literal pins and reset checks.
module tb_controller_fsm;

  localparam int LAT = 3;
  localparam int W   = 20;

  logic        clk;
  logic        rst;
  logic [18:0] instruction;
  logic        COutput, ZOutput;
  logic        pcEn, push, pop, RET, CEn, ZEn, regWrite;
  logic        regFileReadRegister2Select, ALUBInputSelect, DMMemWrite, DMMemRead;
  logic [1:0]  pc3inputMuxSelectAddress, regFileWriteDataSelect, SHROOperation, state_dbg;
  logic [2:0]  ALUOperation;
  logic [W-1:0] dut_vec;

  logic [W-1:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int pcen_cnt = 0;
  int dmr_cnt  = 0;
  int rw_cnt   = 0;

  controller_fsm #(.INSTR_W(19), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .COutput(COutput), .ZOutput(ZOutput),
    .pcEn(pcEn), .pc3inputMuxSelectAddress(pc3inputMuxSelectAddress), .push(push), .pop(pop),
    .RET(RET), .CEn(CEn), .ZEn(ZEn), .regWrite(regWrite),
    .regFileReadRegister2Select(regFileReadRegister2Select), .ALUBInputSelect(ALUBInputSelect),
    .ALUOperation(ALUOperation), .regFileWriteDataSelect(regFileWriteDataSelect),
    .SHROOperation(SHROOperation), .DMMemWrite(DMMemWrite), .DMMemRead(DMMemRead),
    .state_dbg(state_dbg)
  );

  assign dut_vec = {pcEn, pc3inputMuxSelectAddress, push, pop, RET, CEn, ZEn, regWrite,
                    regFileReadRegister2Select, ALUBInputSelect, ALUOperation,
                    regFileWriteDataSelect, SHROOperation, DMMemWrite, DMMemRead};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: run exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // instruction kinds: 0 NOP 1 RALU 2 IALU 3 LDM 4 STM 5 BZ 6 BNZ 7 BC 8 BNC 9 SHRO 10 JMP 11 JSB 12 RET
  function automatic int kind_of(input logic [18:0] ins);
    logic [2:0] t;
    logic [1:0] f;
    t = ins[18:16];
    f = ins[15:14];
    if (ins[18:17] == 2'b00) return 1;
    if (ins[18:17] == 2'b01) return 2;
    if (t == 3'b100) return (f == 2'b00) ? 3 : (f == 2'b01) ? 4 : 0;
    if (t == 3'b101) return 5 + int'(f);
    if (t == 3'b110) return 9;
    return (f == 2'b11) ? 0 : 10 + int'(f);
  endfunction

  function automatic int model_len(input logic [18:0] ins);
    return (kind_of(ins) == 3) ? 2 + LAT : 2;
  endfunction

  // Expected outputs in cycle k of an instruction (k=0 is FETCH).
  function automatic logic [W-1:0] model_cycle(input logic [18:0] ins, input logic c,
                                               input logic z, input int k);
    logic pcen, psh, pp, rt, cen, zen, rw, rr2, alub, dmw, dmr, taken;
    logic [1:0] sel, wd;
    int kd, n;
    {pcen, psh, pp, rt, cen, zen, rw, rr2, alub, dmw, dmr, taken} = '0;
    sel = 2'b00;
    wd  = 2'b00;
    kd  = kind_of(ins);
    n   = model_len(ins);
    if (k == 0) return '0;
    rr2 = 1'b1;
    if (k >= 2) begin
      dmr  = 1'b1;
      alub = 1'b1;
      if (k == n - 1) begin
        rw   = 1'b1;
        wd   = 2'b01;
        pcen = 1'b1;
      end
    end else begin
      case (kd)
        1, 2: begin rw = 1; cen = 1; zen = 1; alub = (kd == 2); pcen = 1; end
        3:    begin dmr = 1; alub = 1; end
        4:    begin dmw = 1; rr2 = 0; alub = 1; pcen = 1; end
        5, 6, 7, 8: begin
          taken = (kd == 5) ? z : (kd == 6) ? !z : (kd == 7) ? c : !c;
          pcen  = 1;
          sel   = taken ? 2'b01 : 2'b00;
        end
        9:  begin rw = 1; cen = 1; zen = 1; wd = 2'b10; pcen = 1; end
        10: begin sel = 2'b10; pcen = 1; end
        11: begin sel = 2'b10; psh = 1; pcen = 1; end
        12: begin sel = 2'b11; pp = 1; rt = 1; pcen = 1; end
        default: pcen = 1;
      endcase
    end
    return {pcen, sel, psh, pp, rt, cen, zen, rw, rr2, alub, ins[16:14], wd, ins[15:14], dmw, dmr};
  endfunction

  // scoreboard: one compare per falling edge
  always @(negedge clk) begin
    if (!rst) begin
      check("reset_outputs_zero", 32'(dut_vec), 32'd0);
    end else if (exp_q.size() > 0) begin
      check("cycle_outputs", 32'(dut_vec), 32'(exp_q.pop_front()));
    end
    if (push && pop) check("push_pop_exclusive", 32'({push, pop}), 32'd0);
    if (regWrite && DMMemWrite) check("rw_dmw_exclusive", 32'({regWrite, DMMemWrite}), 32'd0);
    if (pcEn) pcen_cnt++;
    if (DMMemRead) dmr_cnt++;
    if (regWrite) rw_cnt++;
  end

  // driver: called at posedge+1 of a FETCH cycle; scrambles the instruction bus after fetch
  task automatic do_instr(input string name, input logic [18:0] ins, input logic c, input logic z);
    int n, pc0;
    n = model_len(ins);
    instruction = ins;
    COutput     = c;
    ZOutput     = z;
    for (int k = 0; k < n; k++) exp_q.push_back(model_cycle(ins, c, z, k));
    pc0 = pcen_cnt;
    @(posedge clk); #1;
    instruction = 19'($urandom_range(0, 32'h7FFFF));
    repeat (n - 1) begin @(posedge clk); #1; end
    check({name, "_pcen_once"}, 32'(pcen_cnt - pc0), 32'd1);
  endtask

  localparam logic [18:0] I_ADD  = 19'b00_000_001_010_011_00000;
  localparam logic [18:0] I_ADDI = 19'b01_011_001_010_00001111;
  localparam logic [18:0] I_LDM  = 19'b100_00_001_010_00000100;
  localparam logic [18:0] I_STM  = 19'b100_01_001_010_00000100;
  localparam logic [18:0] I_MNOP = 19'b100_10_00000000000000;
  localparam logic [18:0] I_BZ   = 19'b101_00_00000000001000;
  localparam logic [18:0] I_BNZ  = 19'b101_01_00000000001000;
  localparam logic [18:0] I_BC   = 19'b101_10_00000000001000;
  localparam logic [18:0] I_BNC  = 19'b101_11_00000000001000;
  localparam logic [18:0] I_SHRO = 19'b110_10_001_010_000_00011;
  localparam logic [18:0] I_JMP  = 19'b111_00_00000001000000;
  localparam logic [18:0] I_JSB  = 19'b111_01_00000010000000;
  localparam logic [18:0] I_RET  = 19'b111_10_00000000000000;
  localparam logic [18:0] I_UND  = 19'b111_11_00000000000000;

  initial begin
    int dmr0, rw0;
    rst = 1'b0;
    instruction = '0;
    COutput = 1'b0;
    ZOutput = 1'b0;

    // pin the model against hand-computed vectors
    check("model_len_add", 32'(model_len(I_ADD)), 32'd2);
    check("model_len_ldm", 32'(model_len(I_LDM)), 32'd5);
    check("model_add_exec", 32'(model_cycle(I_ADD, 1'b0, 1'b0, 1)),
          32'(20'b1_00_000_1111_0_000_00_00_00));
    check("model_ldm_last", 32'(model_cycle(I_LDM, 1'b0, 1'b0, 4)),
          32'(20'b1_00_000_0011_1_000_01_00_01));
    check("model_ret_exec", 32'(model_cycle(I_RET, 1'b0, 1'b0, 1)),
          32'(20'b1_11_011_0001_0_110_00_10_00));
    check("model_bz_taken", 32'(model_cycle(I_BZ, 1'b0, 1'b1, 1)),
          32'(20'b1_01_000_0001_0_100_00_00_00));

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    do_instr("add", I_ADD, 1'b0, 1'b0);
    do_instr("addi", I_ADDI, 1'b1, 1'b0);
    do_instr("shro", I_SHRO, 1'b0, 1'b1);
    do_instr("stm", I_STM, 1'b0, 1'b0);
    dmr0 = dmr_cnt;
    do_instr("ldm", I_LDM, 1'b0, 1'b0);
    check("ldm_dmread_cycles", 32'(dmr_cnt - dmr0), 32'd4);
    do_instr("mem_nop", I_MNOP, 1'b0, 1'b0);
    do_instr("bz_t", I_BZ, 1'b0, 1'b1);
    do_instr("bz_nt", I_BZ, 1'b1, 1'b0);
    do_instr("bnz_t", I_BNZ, 1'b0, 1'b0);
    do_instr("bnz_nt", I_BNZ, 1'b0, 1'b1);
    do_instr("bc_t", I_BC, 1'b1, 1'b0);
    do_instr("bc_nt", I_BC, 1'b0, 1'b1);
    do_instr("bnc_t", I_BNC, 1'b0, 1'b1);
    do_instr("bnc_nt", I_BNC, 1'b1, 1'b0);
    do_instr("jmp", I_JMP, 1'b0, 1'b0);
    do_instr("jsb", I_JSB, 1'b0, 1'b0);
    do_instr("ret", I_RET, 1'b1, 1'b1);
    do_instr("undef", I_UND, 1'b0, 1'b0);

    // reset in the middle of an LDM read
    instruction = I_LDM;
    for (int k = 0; k < 3; k++) exp_q.push_back(model_cycle(I_LDM, 1'b0, 1'b0, k));
    rw0 = rw_cnt;
    repeat (3) begin @(posedge clk); #1; end
    exp_q.delete();
    rst = 1'b0;
    #1 check("async_reset_outputs", 32'(dut_vec), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("reset_abort_no_regwrite", 32'(rw_cnt - rw0), 32'd0);
    do_instr("add_after_rst", I_ADD, 1'b0, 1'b0);
    do_instr("ldm_after_rst", I_LDM, 1'b1, 1'b1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
